branch_resolver: RTL and testbench

- Resolves control-transfer instructions in the ID stage of the 16-bit ThinPad pipeline.
- Consumes the 2-bit jump/branch class code produced by the instruction-class decoder, together with operand, PC and offset values.
- Decides whether a branch is taken, computes the target, and presents a held redirect request to the PC unit with a valid/ack handshake.
- Tracks the single architectural delay slot and maintains branch statistics counters.

---
 rtl/branch_resolver.sv | 145 ++++++++++++++
 tb/tb_branch_resolver.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// Branch resolver for the ID stage of the 16-bit ThinPad pipeline.
//
// Resolves jump/branch instructions and decides whether each is taken. A taken
// branch produces a redirect request that is held until the PC unit acks it.
// The resolver also tracks the single delay slot, flags a jump/branch found in a
// delay slot, and keeps saturating counts of resolved and taken branches.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   id_valid        ID stage holds a valid instruction
//   stall           ID instruction is not consumed this cycle
//   flush           discard the pending redirect and the delay-slot tracking
//   is_jb, jb_type  jump/branch flag and class (00 B, 01 JR, 10 BEQZ, 11 BNEZ)
//   rx_val          JR target, or the register compared against zero
//   pc_plus1        address of the instruction after the branch
//   imm_off         sign-extended branch offset
//   redirect_valid  redirect request pending
//   redirect_pc     target PC, stable while redirect_valid is high
//   redirect_ack    PC unit takes the redirect this cycle
//   busy            a redirect is pending and not acked this cycle
//   in_delay_slot   the next consumed ID instruction is the delay slot
//   slot_err        sticky: a jump/branch was seen in a delay slot
//   br_count        resolved jump/branch count (saturating)
//   taken_count     taken jump/branch count (saturating)
module branch_resolver #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic             is_jb,
  input  logic [1:0]       jb_type,
  input  logic [W-1:0]     rx_val,
  input  logic [W-1:0]     pc_plus1,
  input  logic [W-1:0]     imm_off,
  output logic             redirect_valid,
  output logic [W-1:0]     redirect_pc,
  input  logic             redirect_ack,
  output logic             busy,
  output logic             in_delay_slot,
  output logic             slot_err,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [0:0] {StIdle, StSlot} state_e;

  state_e           state_q, state_d;
  logic             rv_q, rv_d;
  logic [W-1:0]     rpc_q, rpc_d;
  logic             slot_err_q, slot_err_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;

  logic         fire;
  logic         taken;
  logic         resolve;
  logic         slot_jb;
  logic [W-1:0] rel_target;
  logic [W-1:0] target;

  assign fire       = id_valid & ~stall & ~flush;
  assign busy       = rv_q & ~redirect_ack;
  assign rel_target = pc_plus1 + imm_off;  // modulo 2^W by construction

  // Branch outcome and target; JR is the only register-indirect class.
  always_comb begin
    taken  = 1'b0;
    target = rel_target;
    case (jb_type)
      2'b00:   taken = 1'b1;
      2'b01: begin
        taken  = 1'b1;
        target = rx_val;
      end
      2'b10:   taken = (rx_val == '0);
      default: taken = (rx_val != '0);
    endcase
  end

  assign resolve = (state_q == StIdle) & fire & is_jb & ~busy;
  assign slot_jb = (state_q == StSlot) & fire & is_jb;

  always_comb begin
    state_d    = state_q;
    rv_d       = rv_q;
    rpc_d      = rpc_q;
    slot_err_d = slot_err_q | slot_jb;
    br_cnt_d   = br_cnt_q;
    tk_cnt_d   = tk_cnt_q;

    unique case (state_q)
      StIdle: if (resolve) state_d = StSlot;
      StSlot: if (fire) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (resolve) begin
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_W'(1);
      if (taken && tk_cnt_q != '1) tk_cnt_d = tk_cnt_q + CNT_W'(1);
    end

    // An ack retires the old request; a branch resolved on the same edge
    // installs the new one, so the load must win over the clear.
    if (rv_q && redirect_ack) rv_d = 1'b0;
    if (resolve && taken) begin
      rv_d  = 1'b1;
      rpc_d = target;
    end

    if (flush) begin
      state_d = StIdle;
      rv_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rv_q       <= 1'b0;
      rpc_q      <= '0;
      slot_err_q <= 1'b0;
      br_cnt_q   <= '0;
      tk_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      rv_q       <= rv_d;
      rpc_q      <= rpc_d;
      slot_err_q <= slot_err_d;
      br_cnt_q   <= br_cnt_d;
      tk_cnt_q   <= tk_cnt_d;
    end
  end

  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign in_delay_slot  = (state_q == StSlot);
  assign slot_err       = slot_err_q;
  assign br_count       = br_cnt_q;
  assign taken_count    = tk_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver. A second instance with 6-bit counters
// shares every input so counter saturation is reachable in a few hundred cycles.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall, flush, is_jb, ack;
  logic [1:0]  jb_type;
  logic [15:0] rx_val, pc_plus1, imm_off;

  logic        rv, busy, ids, serr;
  logic [15:0] rpc, brc, tkc;
  logic        s_rv, s_busy, s_ids, s_serr;
  logic [15:0] s_rpc;
  logic [5:0]  s_brc, s_tkc;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  branch_resolver #(.W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .stall(stall), .flush(flush),
    .is_jb(is_jb), .jb_type(jb_type), .rx_val(rx_val), .pc_plus1(pc_plus1),
    .imm_off(imm_off), .redirect_valid(rv), .redirect_pc(rpc), .redirect_ack(ack),
    .busy(busy), .in_delay_slot(ids), .slot_err(serr), .br_count(brc),
    .taken_count(tkc)
  );

  branch_resolver #(.W(16), .CNT_W(6)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .stall(stall), .flush(flush),
    .is_jb(is_jb), .jb_type(jb_type), .rx_val(rx_val), .pc_plus1(pc_plus1),
    .imm_off(imm_off), .redirect_valid(s_rv), .redirect_pc(s_rpc),
    .redirect_ack(ack), .busy(s_busy), .in_delay_slot(s_ids), .slot_err(s_serr),
    .br_count(s_brc), .taken_count(s_tkc)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    id_valid = 1'b0; stall = 1'b0; flush = 1'b0; is_jb = 1'b0; ack = 1'b0;
    jb_type = 2'b00; rx_val = '0; pc_plus1 = '0; imm_off = '0;
  endtask

  task automatic branch(input logic [1:0] t, input logic [15:0] rx,
                        input logic [15:0] pc, input logic [15:0] imm);
    id_valid = 1'b1; is_jb = 1'b1; jb_type = t; rx_val = rx; pc_plus1 = pc;
    imm_off = imm;
  endtask

  task automatic slot(input logic jb);
    id_valid = 1'b1; is_jb = jb;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1; flush = 1'b1; ack = 1'b1;
    branch(2'b00, 16'h0000, 16'h0010, 16'h0004);
    step();
    vecs++; if (rv !== 1'b0) begin errs++; $display("FAIL reset_rv got=%0h exp=0", rv); end
    vecs++; if (rpc !== 16'h0) begin errs++; $display("FAIL reset_pc got=%h exp=0000", rpc); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    vecs++; if (ids !== 1'b0) begin errs++; $display("FAIL reset_ids got=%0h exp=0", ids); end
    vecs++; if (serr !== 1'b0) begin errs++; $display("FAIL reset_serr got=%0h exp=0", serr); end
    vecs++; if (brc !== 16'h0) begin errs++; $display("FAIL reset_brc got=%h exp=0000", brc); end
    vecs++; if (tkc !== 16'h0) begin errs++; $display("FAIL reset_tkc got=%h exp=0000", tkc); end
    rst = 1'b0;
    drive_idle();
    step();
  endtask

  task automatic test_uncond();
    branch(2'b00, 16'h0000, 16'h0010, 16'hFFFC);
    ack = 1'b1;
    step();
    vecs++; if (rv !== 1'b1) begin errs++; $display("FAIL b_rv got=%0h exp=1", rv); end
    vecs++; if (rpc !== 16'h000C) begin errs++; $display("FAIL b_pc got=%h exp=000c", rpc); end
    vecs++; if (brc !== 16'd1) begin errs++; $display("FAIL b_brc got=%0d exp=1", brc); end
    vecs++; if (tkc !== 16'd1) begin errs++; $display("FAIL b_tkc got=%0d exp=1", tkc); end
    vecs++; if (ids !== 1'b1) begin errs++; $display("FAIL b_ids got=%0h exp=1", ids); end
    slot(1'b0);
    step();
    vecs++; if (rv !== 1'b0) begin errs++; $display("FAIL b_ackclr got=%0h exp=0", rv); end
    vecs++; if (ids !== 1'b0) begin errs++; $display("FAIL b_slotdone got=%0h exp=0", ids); end
    drive_idle();
  endtask

  task automatic test_bz();
    branch(2'b10, 16'h0003, 16'h0050, 16'h0004);
    step();
    vecs++; if (rv !== 1'b0) begin errs++; $display("FAIL bz_nt_rv got=%0h exp=0", rv); end
    vecs++; if (brc !== 16'd2) begin errs++; $display("FAIL bz_nt_brc got=%0d exp=2", brc); end
    vecs++; if (tkc !== 16'd1) begin errs++; $display("FAIL bz_nt_tkc got=%0d exp=1", tkc); end
    vecs++; if (ids !== 1'b1) begin errs++; $display("FAIL bz_nt_ids got=%0h exp=1", ids); end
    slot(1'b0);
    step();
    vecs++; if (ids !== 1'b0) begin errs++; $display("FAIL bz_nt_slot got=%0h exp=0", ids); end
    branch(2'b10, 16'h0000, 16'h0100, 16'h0020);
    step();
    vecs++; if (rv !== 1'b1) begin errs++; $display("FAIL bz_t_rv got=%0h exp=1", rv); end
    vecs++; if (rpc !== 16'h0120) begin errs++; $display("FAIL bz_t_pc got=%h exp=0120", rpc); end
    vecs++; if (brc !== 16'd3) begin errs++; $display("FAIL bz_t_brc got=%0d exp=3", brc); end
    vecs++; if (tkc !== 16'd2) begin errs++; $display("FAIL bz_t_tkc got=%0d exp=2", tkc); end
    slot(1'b0);
    ack = 1'b1;
    step();
    vecs++; if (rv !== 1'b0) begin errs++; $display("FAIL bz_t_ack got=%0h exp=0", rv); end
    drive_idle();
  endtask

  task automatic test_jr_hold();
    branch(2'b01, 16'hBEEF, 16'h0200, 16'h0040);
    step();
    vecs++; if (rv !== 1'b1) begin errs++; $display("FAIL jr_rv got=%0h exp=1", rv); end
    vecs++; if (rpc !== 16'hBEEF) begin errs++; $display("FAIL jr_pc got=%h exp=beef", rpc); end
    vecs++; if (brc !== 16'd4) begin errs++; $display("FAIL jr_brc got=%0d exp=4", brc); end
    vecs++; if (tkc !== 16'd3) begin errs++; $display("FAIL jr_tkc got=%0d exp=3", tkc); end
    slot(1'b0);
    step();
    vecs++; if (ids !== 1'b0) begin errs++; $display("FAIL jr_slot got=%0h exp=0", ids); end
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      if (i == 0) branch(2'b00, 16'h0000, 16'h0700, 16'h0001);
      #1;
      vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL hold_busy[%0d] got=%0h exp=1", i, busy); end
      step();
      vecs++; if (rv !== 1'b1) begin errs++; $display("FAIL hold_rv[%0d] got=%0h exp=1", i, rv); end
      vecs++; if (rpc !== 16'hBEEF) begin errs++; $display("FAIL hold_pc[%0d] got=%h exp=beef", i, rpc); end
      vecs++; if (brc !== 16'd4) begin errs++; $display("FAIL hold_brc[%0d] got=%0d exp=4", i, brc); end
      vecs++; if (tkc !== 16'd3) begin errs++; $display("FAIL hold_tkc[%0d] got=%0d exp=3", i, tkc); end
      vecs++; if (ids !== 1'b0) begin errs++; $display("FAIL hold_ids[%0d] got=%0h exp=0", i, ids); end
    end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    // Ack of BEEF and acceptance of the next branch on the same edge.
    branch(2'b00, 16'h0000, 16'h0300, 16'h0005);
    ack = 1'b1;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_busy got=%0h exp=0", busy); end
    step();
    vecs++; if (rv !== 1'b1) begin errs++; $display("FAIL b2b_rv got=%0h exp=1", rv); end
    vecs++; if (rpc !== 16'h0305) begin errs++; $display("FAIL b2b_pc got=%h exp=0305", rpc); end
    vecs++; if (brc !== 16'd5) begin errs++; $display("FAIL b2b_brc got=%0d exp=5", brc); end
    vecs++; if (tkc !== 16'd4) begin errs++; $display("FAIL b2b_tkc got=%0d exp=4", tkc); end
    vecs++; if (ids !== 1'b1) begin errs++; $display("FAIL b2b_ids got=%0h exp=1", ids); end
    slot(1'b0);
    step();
    vecs++; if (rv !== 1'b0) begin errs++; $display("FAIL b2b_ack got=%0h exp=0", rv); end
    drive_idle();
  endtask

  task automatic test_slot_err();
    branch(2'b00, 16'h0000, 16'h0400, 16'h0010);
    step();
    vecs++; if (rpc !== 16'h0410) begin errs++; $display("FAIL se_pc got=%h exp=0410", rpc); end
    branch(2'b01, 16'h9999, 16'h0401, 16'h0000);
    step();
    vecs++; if (serr !== 1'b1) begin errs++; $display("FAIL se_flag got=%0h exp=1", serr); end
    vecs++; if (rv !== 1'b1) begin errs++; $display("FAIL se_rv got=%0h exp=1", rv); end
    vecs++; if (rpc !== 16'h0410) begin errs++; $display("FAIL se_pc2 got=%h exp=0410", rpc); end
    vecs++; if (brc !== 16'd6) begin errs++; $display("FAIL se_brc got=%0d exp=6", brc); end
    vecs++; if (tkc !== 16'd5) begin errs++; $display("FAIL se_tkc got=%0d exp=5", tkc); end
    vecs++; if (ids !== 1'b0) begin errs++; $display("FAIL se_ids got=%0h exp=0", ids); end
    drive_idle();
    ack = 1'b1;
    step();
    vecs++; if (rv !== 1'b0) begin errs++; $display("FAIL se_ack got=%0h exp=0", rv); end
    vecs++; if (serr !== 1'b1) begin errs++; $display("FAIL se_sticky got=%0h exp=1", serr); end
    drive_idle();
  endtask

  task automatic test_stall();
    branch(2'b01, 16'h1234, 16'h0000, 16'h0000);
    stall = 1'b1;
    step();
    vecs++; if (rv !== 1'b0) begin errs++; $display("FAIL st_rv got=%0h exp=0", rv); end
    vecs++; if (brc !== 16'd6) begin errs++; $display("FAIL st_brc got=%0d exp=6", brc); end
    vecs++; if (ids !== 1'b0) begin errs++; $display("FAIL st_ids got=%0h exp=0", ids); end
    stall = 1'b0;
    step();
    vecs++; if (rpc !== 16'h1234) begin errs++; $display("FAIL st_pc got=%h exp=1234", rpc); end
    vecs++; if (brc !== 16'd7) begin errs++; $display("FAIL st_brc2 got=%0d exp=7", brc); end
    vecs++; if (tkc !== 16'd6) begin errs++; $display("FAIL st_tkc got=%0d exp=6", tkc); end
    slot(1'b0);
    stall = 1'b1;
    ack = 1'b1;
    step();
    vecs++; if (ids !== 1'b1) begin errs++; $display("FAIL st_slothold got=%0h exp=1", ids); end
    vecs++; if (rv !== 1'b0) begin errs++; $display("FAIL st_ack got=%0h exp=0", rv); end
    stall = 1'b0;
    ack = 1'b0;
    step();
    vecs++; if (ids !== 1'b0) begin errs++; $display("FAIL st_slotdone got=%0h exp=0", ids); end
    drive_idle();
  endtask

  task automatic test_wrap();
    branch(2'b11, 16'h0001, 16'hFFFF, 16'h0002);
    step();
    vecs++; if (rv !== 1'b1) begin errs++; $display("FAIL wr_rv got=%0h exp=1", rv); end
    vecs++; if (rpc !== 16'h0001) begin errs++; $display("FAIL wr_pc got=%h exp=0001", rpc); end
    vecs++; if (brc !== 16'd8) begin errs++; $display("FAIL wr_brc got=%0d exp=8", brc); end
    vecs++; if (tkc !== 16'd7) begin errs++; $display("FAIL wr_tkc got=%0d exp=7", tkc); end
    slot(1'b0);
    step();
    drive_idle();
    // Branch-if-nonzero with a zero operand is not taken.
    branch(2'b11, 16'h0000, 16'h0800, 16'h0010);
    ack = 1'b1;
    step();
    vecs++; if (rv !== 1'b0) begin errs++; $display("FAIL bnz_nt_rv got=%0h exp=0", rv); end
    vecs++; if (tkc !== 16'd7) begin errs++; $display("FAIL bnz_nt_tkc got=%0d exp=7", tkc); end
    slot(1'b0);
    step();
    drive_idle();
  endtask

  task automatic test_flush();
    branch(2'b00, 16'h0000, 16'h0500, 16'h0000);
    step();
    slot(1'b0);
    step();
    vecs++; if (rv !== 1'b1) begin errs++; $display("FAIL fl_pend got=%0h exp=1", rv); end
    branch(2'b00, 16'h0000, 16'h0600, 16'h0001);
    flush = 1'b1;
    ack = 1'b1;
    step();
    vecs++; if (rv !== 1'b0) begin errs++; $display("FAIL fl_rv got=%0h exp=0", rv); end
    vecs++; if (ids !== 1'b0) begin errs++; $display("FAIL fl_ids got=%0h exp=0", ids); end
    vecs++; if (brc !== 16'd10) begin errs++; $display("FAIL fl_brc got=%0d exp=10", brc); end
    vecs++; if (tkc !== 16'd8) begin errs++; $display("FAIL fl_tkc got=%0d exp=8", tkc); end
    drive_idle();
    branch(2'b01, 16'h0777, 16'h0000, 16'h0000);
    step();
    vecs++; if (ids !== 1'b1) begin errs++; $display("FAIL fl2_ids got=%0h exp=1", ids); end
    drive_idle();
    flush = 1'b1;
    step();
    vecs++; if (ids !== 1'b0) begin errs++; $display("FAIL fl2_slot got=%0h exp=0", ids); end
    vecs++; if (rv !== 1'b0) begin errs++; $display("FAIL fl2_rv got=%0h exp=0", rv); end
    vecs++; if (brc !== 16'd11) begin errs++; $display("FAIL fl2_brc got=%0d exp=11", brc); end
    vecs++; if (serr !== 1'b1) begin errs++; $display("FAIL fl2_serr got=%0h exp=1", serr); end
    drive_idle();
    ack = 1'b1;
    step();
    vecs++; if (rv !== 1'b0) begin errs++; $display("FAIL idle_ack got=%0h exp=0", rv); end
    drive_idle();
  endtask

  task automatic test_saturation();
    // 11 resolved / 9 taken so far; 60 more taken branches.
    for (int i = 0; i < 60; i++) begin
      branch(2'b01, 16'h0042, 16'h0000, 16'h0000);
      ack = 1'b1;
      step();
      slot(1'b0);
      step();
      drive_idle();
    end
    step();
    vecs++; if (s_brc !== 6'h3F) begin errs++; $display("FAIL sat_brc got=%h exp=3f", s_brc); end
    vecs++; if (s_tkc !== 6'h3F) begin errs++; $display("FAIL sat_tkc got=%h exp=3f", s_tkc); end
    vecs++; if (brc !== 16'd71) begin errs++; $display("FAIL sat_main_brc got=%0d exp=71", brc); end
    vecs++; if (tkc !== 16'd69) begin errs++; $display("FAIL sat_main_tkc got=%0d exp=69", tkc); end
    vecs++; if (s_rv !== 1'b0) begin errs++; $display("FAIL sat_rv got=%0h exp=0", s_rv); end
  endtask

  initial begin
    test_reset();
    test_uncond();
    test_bz();
    test_jr_hold();
    test_back_to_back();
    test_slot_err();
    test_stall();
    test_wrap();
    test_flush();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
